serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be a multiple of DIGIT, else elaboration fails.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rstN  input  1  reset, synchronous and active-low.
REQ-005 inValid  input  1  operands x, y, borrowIn are presented.
REQ-006 inReady  output  1  block accepts operands this cycle.
REQ-007 x  input  WIDTH  minuend.
REQ-008 y  input  WIDTH  subtrahend.
REQ-009 borrowIn  input  1  borrow into the least significant digit.
REQ-010 outValid  output  1  result fields are valid.
REQ-011 outReady  input  1  consumer takes the result this cycle.
REQ-012 xy  output  WIDTH  difference x - y - borrowIn mod 2^WIDTH.
REQ-013 borrowOut  output  1  borrow out of the MSB; 1 iff unsigned x < y + borrowIn.
REQ-014 overflow  output  1  signed (two's-complement) x - y - borrowIn not representable in WIDTH bits.

Function
REQ-015 FSM states IDLE, BUSY, DONE; inReady SHALL equal (state == IDLE); outValid SHALL equal (state == DONE).
REQ-016 IDLE: on inValid && inReady, latch x, y, borrowIn, clear digit counter, go BUSY; otherwise stay IDLE.
REQ-017 BUSY: each cycle subtract one DIGIT-bit slice, LSB slice first, using the registered running borrow; store the slice result; increment counter.
REQ-018 BUSY: after the slice with index WIDTH/DIGIT-1, capture final borrow into borrowOut, compute overflow, go DONE.
REQ-019 Latency: accept at edge k SHALL give outValid high from edge k + WIDTH/DIGIT; with WIDTH==DIGIT latency is 1.
REQ-020 DONE: xy, borrowOut, overflow held stable while outValid && !outReady.
REQ-021 DONE: on outReady go IDLE; inReady rises the cycle after result handoff (no same-cycle accept and release).
REQ-022 inValid in BUSY or DONE is ignored; x, y, borrowIn changes after acceptance do not affect the result.
REQ-023 overflow SHALL be 1 iff x[MSB] != y[MSB] and xy[MSB] != x[MSB] (borrowIn included in xy).
REQ-024 xy SHALL show 0 outside DONE and keeps its value only in DONE.

Reset
REQ-025 rstN low at a rising edge SHALL force state IDLE, counter 0, running borrow 0, xy 0, borrowOut 0, overflow 0, regardless of current state.
REQ-026 Reset mid-BUSY or mid-DONE SHALL abandon the operation; no outValid for it is ever produced.
REQ-027 First cycle after rstN goes high: inReady = 1, outValid = 0.

Structure
REQ-028 Shared package serial_subtractor_pkg holds the state enum typedef (IDLE, BUSY, DONE).
REQ-029 One sub-module digit_subtractor (combinational, DIGIT-bit, borrow-ripple: x, y, borrowIn -> xy, borrowOut), instantiated once.
REQ-030 Counter width SHALL be $clog2(WIDTH/DIGIT) with minimum 1 bit.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 x=0x0000, y=0x0001, borrowIn=0 -> after 4 cycles xy=0xFFFF, borrowOut=1, overflow=0.
REQ-032 x=0x8000, y=0x0000, borrowIn=1 -> xy=0x7FFF, borrowOut=0, overflow=1; x=0x7FFF, y=0xFFFF, borrowIn=0 -> xy=0x8000, borrowOut=1, overflow=1.
REQ-033 outReady held low 10 cycles after outValid, inValid toggled with new operands -> result stable, inReady=0 throughout, new operands not taken until cycle after outReady.
REQ-034 rstN low at third BUSY cycle -> next cycle IDLE, inReady=1, outValid never asserts for that operation.
REQ-035 Exhaustive WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=4 sweep of all 512 {x,y,borrowIn}, checking {borrowOut,xy} == x - y - borrowIn (5-bit) and latency 4 and 1 respectively.
REQ-036 Back-to-back: outReady tied high, inValid tied high -> one result every WIDTH/DIGIT+2 cycles, no drops or duplicates.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the serial subtractor slice.
//   state_e   : controller states (IDLE, BUSY, DONE)
//   cnt_width : digit-counter width, $clog2(n) but never below one bit
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   inValid/inReady   : operand handshake (x, y, borrowIn)
//   outValid/outReady : result handshake (xy, borrowOut, overflow)
// master = operand producer / result consumer, slave = the subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             borrowIn;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] xy;
   logic             borrowOut;
   logic             overflow;

   modport master (
      output inValid, x, y, borrowIn, outReady,
      input  inReady, outValid, xy, borrowOut, overflow
   );

   modport slave (
      input  inValid, x, y, borrowIn, outReady,
      output inReady, outValid, xy, borrowOut, overflow
   );
endinterface

// File: rtl/serial_subtractor_digit.sv
// digit_subtractor: combinational DIGIT-bit borrow-ripple subtractor.
//   x, y      : digit operands
//   borrowIn  : borrow into bit 0
//   xy        : x - y - borrowIn (mod 2^DIGIT)
//   borrowOut : borrow out of the top bit
module digit_subtractor #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             borrowIn,
   output logic [DIGIT-1:0] xy,
   output logic             borrowOut
);

   logic b;

   always_comb begin
      b  = borrowIn;
      xy = '0;
      for (int i = 0; i < DIGIT; i++) begin
         xy[i] = x[i] ^ y[i] ^ b;
         // borrow when x bit is 0 and y bit 1, or bits equal with borrow pending
         b     = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b);
      end
      borrowOut = b;
   end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes x - y - borrowIn one DIGIT-bit slice per cycle,
// LSB slice first, and reports the difference, final borrow and signed
// overflow through a valid/ready result handshake.
//   clk  : clock, rising edge
//   rstN : synchronous active-low reset
//   bus  : serial_subtractor_if.slave (operand and result handshakes)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | inReady high, waiting for operands
// BUSY  | subtracting slice cnt_q with the registered running borrow
// DONE  | outValid high, result held until outReady
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic               clk,
   input logic               rstN,
   serial_subtractor_if.slave bus
);

   localparam int            NSLICE = WIDTH / DIGIT;
   localparam int            CW     = cnt_width(NSLICE);
   localparam logic [CW-1:0] LAST   = CW'(NSLICE - 1);

   if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic             borrow_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] xy_q;
   logic             borrow_out_q;
   logic             overflow_q;
   logic             overflow_d;

   logic [31:0]      base;
   logic [DIGIT-1:0] slice_x;
   logic [DIGIT-1:0] slice_y;
   logic [DIGIT-1:0] slice_d;
   logic             slice_b;

   assign base    = 32'(cnt_q) * 32'(DIGIT);
   assign slice_x = x_q[base +: DIGIT];
   assign slice_y = y_q[base +: DIGIT];

   digit_subtractor #(.DIGIT(DIGIT)) u_digit (
      .x         (slice_x),
      .y         (slice_y),
      .borrowIn  (borrow_q),
      .xy        (slice_d),
      .borrowOut (slice_b)
   );

   // res_d is the partial result including the slice being computed now, so
   // on the last slice it is the full difference and overflow can use its MSB.
   always_comb begin
      res_d                = res_q;
      res_d[base +: DIGIT] = slice_d;
      overflow_d           = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) & (res_d[WIDTH-1] ^ x_q[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         borrow_q     <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         res_q        <= '0;
         xy_q         <= '0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.inValid) begin
                  x_q      <= bus.x;
                  y_q      <= bus.y;
                  borrow_q <= bus.borrowIn;
                  cnt_q    <= '0;
                  res_q    <= '0;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               res_q    <= res_d;
               borrow_q <= slice_b;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  xy_q         <= res_d;
                  borrow_out_q <= slice_b;
                  overflow_q   <= overflow_d;
                  state_q      <= DONE;
               end
            end
            DONE: begin
               // result fields read zero again once the consumer has them
               if (bus.outReady) begin
                  xy_q         <= '0;
                  borrow_out_q <= 1'b0;
                  overflow_q   <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.inReady   = (state_q == IDLE);
   assign bus.outValid  = (state_q == DONE);
   assign bus.xy        = xy_q;
   assign bus.borrowOut = borrow_out_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 16/4 instance for directed, random, stall,
// reset and streaming scenarios; 4/1 and 4/4 instances for the exhaustive sweep.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rstN;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(16)) b16 ();
   serial_subtractor_if #(.WIDTH(4))  b41 ();
   serial_subtractor_if #(.WIDTH(4))  b44 ();

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rstN(rstN), .bus(b16));
   serial_subtractor #(.WIDTH(4),  .DIGIT(1)) u41 (.clk(clk), .rstN(rstN), .bus(b41));
   serial_subtractor #(.WIDTH(4),  .DIGIT(4)) u44 (.clk(clk), .rstN(rstN), .bus(b44));

   // Reference: plain integer arithmetic on the operand values.
   function automatic void ref_sub(input int w, input longint x, input longint y, input longint b,
                                   output longint d, output bit bo, output bit ov);
      longint full, half, diff, sx, sy, sd;
      full = longint'(1) << w;
      half = full >> 1;
      diff = x - y - b;
      bo   = (diff < 0);
      d    = (diff + full) % full;
      sx   = (x >= half) ? x - full : x;
      sy   = (y >= half) ? y - full : y;
      sd   = sx - sy - b;
      ov   = (sd < -half) || (sd > half - 1);
   endfunction

   // One transaction on the 16-bit instance; operands are scrambled right
   // after acceptance. Returns result and accept-to-outValid edge count.
   task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic b,
                       output logic [15:0] rxy, output logic rbo, output logic rov, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!b16.inReady && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      b16.inValid = 1'b1; b16.x = x; b16.y = y; b16.borrowIn = b;
      @(posedge clk);
      @(negedge clk);
      b16.inValid = 1'b0; b16.x = 16'($urandom); b16.y = 16'($urandom); b16.borrowIn = 1'($urandom);
      lat = 0;
      while (!b16.outValid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      rxy = b16.xy; rbo = b16.borrowOut; rov = b16.overflow;
      b16.outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b16.outReady = 1'b0;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (b16.inReady !== 1'b1 || b41.inReady !== 1'b1 || b44.inReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_inReady: got %b%b%b expected 111", b16.inReady, b41.inReady, b44.inReady);
      end
      checks++;
      if (b16.outValid !== 1'b0 || b41.outValid !== 1'b0 || b44.outValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_outValid: got %b%b%b expected 000", b16.outValid, b41.outValid, b44.outValid);
      end
      checks++;
      if (b16.xy !== 16'h0 || b16.borrowOut !== 1'b0 || b16.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_result: got xy=%h bo=%b ov=%b expected 0000 0 0", b16.xy, b16.borrowOut, b16.overflow);
      end
   endtask

   task automatic test_directed();
      logic [15:0] tx[3], ty[3], exy[3];
      logic        tb_[3], ebo[3], eov[3];
      logic [15:0] rxy;
      logic        rbo, rov;
      int          lat;
      tx[0] = 16'h0000; ty[0] = 16'h0001; tb_[0] = 1'b0; exy[0] = 16'hFFFF; ebo[0] = 1'b1; eov[0] = 1'b0;
      tx[1] = 16'h8000; ty[1] = 16'h0000; tb_[1] = 1'b1; exy[1] = 16'h7FFF; ebo[1] = 1'b0; eov[1] = 1'b1;
      tx[2] = 16'h7FFF; ty[2] = 16'hFFFF; tb_[2] = 1'b0; exy[2] = 16'h8000; ebo[2] = 1'b1; eov[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op16(tx[i], ty[i], tb_[i], rxy, rbo, rov, lat);
         checks++;
         if (rxy !== exy[i] || rbo !== ebo[i] || rov !== eov[i]) begin
            errors++;
            $display("FAIL directed_%0d: got xy=%h bo=%b ov=%b expected xy=%h bo=%b ov=%b",
                     i, rxy, rbo, rov, exy[i], ebo[i], eov[i]);
         end
         checks++;
         if (lat !== 4) begin
            errors++;
            $display("FAIL directed_latency_%0d: got %0d expected 4", i, lat);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] x, y, rxy;
      logic        b, rbo, rov;
      longint      d;
      bit          ebo, eov;
      int          lat;
      for (int i = 0; i < 150; i++) begin
         x = 16'($urandom); y = 16'($urandom); b = 1'($urandom);
         if (i % 8 == 0) y = x;
         op16(x, y, b, rxy, rbo, rov, lat);
         ref_sub(16, longint'(x), longint'(y), longint'(b), d, ebo, eov);
         checks++;
         if (rxy !== d[15:0] || rbo !== ebo || rov !== eov || lat !== 4) begin
            errors++;
            $display("FAIL random x=%h y=%h b=%b: got xy=%h bo=%b ov=%b lat=%0d expected xy=%h bo=%b ov=%b lat=4",
                     x, y, b, rxy, rbo, rov, lat, d[15:0], ebo, eov);
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] ax, ay, bx, by;
      logic        ab, bb;
      longint      d;
      bit          ebo, eov;
      int          lat;
      ax = 16'($urandom); ay = 16'($urandom); ab = 1'($urandom);
      bx = 16'($urandom); by = 16'($urandom); bb = 1'($urandom);
      @(negedge clk);
      b16.inValid = 1'b1; b16.x = ax; b16.y = ay; b16.borrowIn = ab;
      @(posedge clk);
      @(negedge clk);
      b16.inValid = 1'b0;
      lat = 0;
      while (!b16.outValid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      ref_sub(16, longint'(ax), longint'(ay), longint'(ab), d, ebo, eov);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (b16.outValid !== 1'b1 || b16.inReady !== 1'b0 || b16.xy !== d[15:0] ||
             b16.borrowOut !== ebo || b16.overflow !== eov) begin
            errors++;
            $display("FAIL stall_hold_%0d: got v=%b r=%b xy=%h bo=%b ov=%b expected v=1 r=0 xy=%h bo=%b ov=%b",
                     i, b16.outValid, b16.inReady, b16.xy, b16.borrowOut, b16.overflow, d[15:0], ebo, eov);
         end
         b16.inValid = ~b16.inValid; b16.x = 16'($urandom); b16.y = 16'($urandom); b16.borrowIn = 1'($urandom);
         @(negedge clk);
      end
      b16.inValid = 1'b1; b16.x = bx; b16.y = by; b16.borrowIn = bb; b16.outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b16.outReady = 1'b0;
      checks++;
      if (b16.inReady !== 1'b1 || b16.outValid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got r=%b v=%b expected r=1 v=0", b16.inReady, b16.outValid);
      end
      @(posedge clk);
      @(negedge clk);
      b16.inValid = 1'b0; b16.x = 16'($urandom); b16.y = 16'($urandom);
      lat = 0;
      while (!b16.outValid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      ref_sub(16, longint'(bx), longint'(by), longint'(bb), d, ebo, eov);
      checks++;
      if (b16.xy !== d[15:0] || b16.borrowOut !== ebo || b16.overflow !== eov || lat !== 4) begin
         errors++;
         $display("FAIL stall_next_op: got xy=%h bo=%b ov=%b lat=%0d expected xy=%h bo=%b ov=%b lat=4",
                  b16.xy, b16.borrowOut, b16.overflow, lat, d[15:0], ebo, eov);
      end
      b16.outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b16.outReady = 1'b0;
   endtask

   task automatic test_reset_mid_busy();
      int          seen;
      logic [15:0] rxy;
      logic        rbo, rov;
      int          lat;
      longint      d;
      bit          ebo, eov;
      @(negedge clk);
      b16.inValid = 1'b1; b16.x = 16'h1234; b16.y = 16'h0FF1; b16.borrowIn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b16.inValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      checks++;
      if (b16.inReady !== 1'b1 || b16.outValid !== 1'b0 || b16.xy !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid_busy: got r=%b v=%b xy=%h expected r=1 v=0 xy=0000",
                  b16.inReady, b16.outValid, b16.xy);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (b16.outValid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_abandon: got %0d outValid cycles expected 0", seen);
      end
      op16(16'h00FF, 16'h0100, 1'b0, rxy, rbo, rov, lat);
      ref_sub(16, 64'h00FF, 64'h0100, 0, d, ebo, eov);
      checks++;
      if (rxy !== d[15:0] || rbo !== ebo || rov !== eov || lat !== 4) begin
         errors++;
         $display("FAIL after_reset_op: got xy=%h bo=%b ov=%b lat=%0d expected xy=%h bo=%b ov=%b lat=4",
                  rxy, rbo, rov, lat, d[15:0], ebo, eov);
      end
   endtask

   task automatic test_exhaustive();
      logic [4:0] e;
      logic [3:0] r41, r44;
      logic       bo41, bo44, ov41, ov44;
      longint     d;
      bit         ebo, eov;
      int         lat, lat41, lat44, guard;
      bit         got41, got44;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int b = 0; b < 2; b++) begin
               @(negedge clk);
               guard = 0;
               while (!(b41.inReady && b44.inReady) && guard < 20) begin
                  @(negedge clk);
                  guard++;
               end
               b41.inValid = 1'b1; b41.x = 4'(x); b41.y = 4'(y); b41.borrowIn = 1'(b);
               b44.inValid = 1'b1; b44.x = 4'(x); b44.y = 4'(y); b44.borrowIn = 1'(b);
               @(posedge clk);
               @(negedge clk);
               b41.inValid = 1'b0; b41.x = 4'($urandom); b41.y = 4'($urandom);
               b44.inValid = 1'b0; b44.x = 4'($urandom); b44.y = 4'($urandom);
               got41 = 0; got44 = 0; lat = 0; lat41 = -1; lat44 = -1;
               r41 = 'x; r44 = 'x; bo41 = 'x; bo44 = 'x; ov41 = 'x; ov44 = 'x;
               while (!(got41 && got44) && lat < 20) begin
                  @(posedge clk);
                  lat++;
                  @(negedge clk);
                  if (!got41 && b41.outValid) begin
                     got41 = 1; lat41 = lat; r41 = b41.xy; bo41 = b41.borrowOut; ov41 = b41.overflow;
                  end
                  if (!got44 && b44.outValid) begin
                     got44 = 1; lat44 = lat; r44 = b44.xy; bo44 = b44.borrowOut; ov44 = b44.overflow;
                  end
               end
               e = 5'(x) - 5'(y) - 5'(b);
               ref_sub(4, longint'(x), longint'(y), longint'(b), d, ebo, eov);
               checks++;
               if ({bo41, r41} !== e || ov41 !== eov || lat41 != 4) begin
                  errors++;
                  $display("FAIL sweep_d1 x=%h y=%h b=%0d: got %b ov=%b lat=%0d expected %b ov=%b lat=4",
                           x, y, b, {bo41, r41}, ov41, lat41, e, eov);
               end
               checks++;
               if ({bo44, r44} !== e || ov44 !== eov || lat44 != 1) begin
                  errors++;
                  $display("FAIL sweep_d4 x=%h y=%h b=%0d: got %b ov=%b lat=%0d expected %b ov=%b lat=1",
                           x, y, b, {bo44, r44}, ov44, lat44, e, eov);
               end
               b41.outReady = 1'b1; b44.outReady = 1'b1;
               @(posedge clk);
               @(negedge clk);
               b41.outReady = 1'b0; b44.outReady = 1'b0;
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] q[$];
      logic [17:0] exp_r;
      longint      d;
      bit          ebo, eov;
      int          pushed, nres, last_t;
      pushed = 0; nres = 0; last_t = -1;
      @(negedge clk);
      b16.outReady = 1'b1;
      b16.inValid  = 1'b1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (b16.outValid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra: got result %h with none outstanding", b16.xy);
            end else begin
               exp_r = q.pop_front();
               if ({b16.overflow, b16.borrowOut, b16.xy} !== exp_r) begin
                  errors++;
                  $display("FAIL b2b_result: got %h expected %h",
                           {b16.overflow, b16.borrowOut, b16.xy}, exp_r);
               end
            end
            if (last_t >= 0) begin
               checks++;
               if (cyc - last_t != 6) begin
                  errors++;
                  $display("FAIL b2b_interval: got %0d expected 6", cyc - last_t);
               end
            end
            last_t = cyc;
            nres++;
         end
         if (cyc < 80) begin
            b16.x = 16'($urandom); b16.y = 16'($urandom); b16.borrowIn = 1'($urandom);
            if (b16.inReady) begin
               ref_sub(16, longint'(b16.x), longint'(b16.y), longint'(b16.borrowIn), d, ebo, eov);
               q.push_back({eov, ebo, d[15:0]});
               pushed++;
            end
         end else begin
            b16.inValid = 1'b0;
         end
         @(negedge clk);
      end
      b16.outReady = 1'b0;
      checks++;
      if (nres != pushed || pushed < 12) begin
         errors++;
         $display("FAIL b2b_count: got %0d results for %0d accepted (need >= 12)", nres, pushed);
      end
   endtask

   initial begin
      rstN = 1'b0;
      b16.inValid = 1'b0; b16.x = '0; b16.y = '0; b16.borrowIn = 1'b0; b16.outReady = 1'b0;
      b41.inValid = 1'b0; b41.x = '0; b41.y = '0; b41.borrowIn = 1'b0; b41.outReady = 1'b0;
      b44.inValid = 1'b0; b44.x = '0; b44.y = '0; b44.borrowIn = 1'b0; b44.outReady = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_stall();
      test_reset_mid_busy();
      test_exhaustive();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
